// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared constants, types and FSM encoding for the HUB75 receive capture
// Purpose: geometry of the captured panel (COLS x 2*ROWS), pixel types and the
//          commit FSM state encoding used by hub75_rx_capture.
// Ports:   none (package).
package hub75_pkg;

  localparam int COLS     = 64;
  localparam int ROW_BITS = 4;
  localparam int ROWS     = 1 << ROW_BITS;
  localparam int COL_BITS = 6;
  localparam int CNT_BITS = COL_BITS + 1;

  localparam logic [CNT_BITS-1:0] COLS_CNT = CNT_BITS'(COLS);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  typedef logic [2:0] rgb_t;

  typedef struct packed {
    rgb_t rgb0;
    rgb_t rgb1;
  } pix_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/hub75_rx_sync.sv
// rtl/hub75_rx_sync.sv - 2-flop synchronizer with aligned delay stage and rising-edge detect
// Purpose: brings W asynchronous panel lines into the clk domain. A third
//          stage holds the previous synchronized value for edge detection,
//          and the rise flag is registered so that q_o and rise_o change on
//          the same clk edge (3 clk pin-to-output latency for both).
// Ports:   clk, rst    clock, asynchronous active-high reset
//          d_i [W]     asynchronous inputs
//          q_o [W]     synchronized, delayed value
//          rise_o [W]  one-cycle pulse per synchronized rising edge
module hub75_rx_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] s1_q, s2_q, s3_q, rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      rise_q <= '0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= s2_q & ~s3_q;
    end
  end

  assign q_o    = s3_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/hub75_rx_capture.sv
// rtl/hub75_rx_capture.sv - HUB75 panel-side receiver rebuilding latched rows into a frame memory
// Purpose: samples the HUB75 link, shifts pixel pairs into a row buffer,
//          commits each latched row pair into a 32x64 RGB frame memory and
//          exposes it through a 1-cycle random-access read port.
// Option:  HUB75_RX_OE_CHECK_EN - flag LAT rises seen while OE is active (low).
// Ports:   clk, rst                      clock, asynchronous active-high reset
//          hub_sclk/lat/oe/addr/rgb0/rgb1 HUB75 link inputs (asynchronous)
//          rd_en, rd_row, rd_col         read request
//          rd_valid, rd_rgb              read response, one clk after rd_en
//          row_done, frame_done          commit completion pulses
//          err_clr                       clears sticky error flags
//          err_short/long/overrun/oe     sticky protocol error flags
module hub75_rx_capture
  import hub75_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                hub_sclk,
  input  logic                hub_lat,
  input  logic                hub_oe,
  input  logic [ROW_BITS-1:0] hub_addr,
  input  logic [2:0]          hub_rgb0,
  input  logic [2:0]          hub_rgb1,
  input  logic                rd_en,
  input  logic [ROW_BITS:0]   rd_row,
  input  logic [COL_BITS-1:0] rd_col,
  output logic                rd_valid,
  output logic [2:0]          rd_rgb,
  output logic                row_done,
  output logic                frame_done,
  input  logic                err_clr,
  output logic                err_short,
  output logic                err_long,
  output logic                err_overrun,
  output logic                err_oe
);

  localparam int DW = 1 + ROW_BITS + 6;

  logic [1:0]          edge_lvl_unused, edge_rise;
  logic [DW-1:0]       data_s, data_rise_unused;
  logic                sclk_rise, lat_rise, lat_accept, sclk_wr;
  logic                oe_s;
  logic [ROW_BITS-1:0] addr_s;
  rgb_t                rgb0_s, rgb1_s;

  hub75_rx_sync #(.W(2)) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({hub_lat, hub_sclk}),
    .q_o    (edge_lvl_unused),
    .rise_o (edge_rise)
  );

  // Same depth as the edge path so data/addr/OE line up with the detected edge.
  hub75_rx_sync #(.W(DW)) u_sync_data (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({hub_oe, hub_addr, hub_rgb0, hub_rgb1}),
    .q_o    (data_s),
    .rise_o (data_rise_unused)
  );

  assign sclk_rise = edge_rise[0];
  assign lat_rise  = edge_rise[1];
  assign oe_s      = data_s[DW-1];
  assign addr_s    = data_s[DW-2 -: ROW_BITS];
  assign rgb0_s    = data_s[5:3];
  assign rgb1_s    = data_s[2:0];

  state_t              state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [CNT_BITS-1:0] shift_cnt_q;
  logic [ROW_BITS-1:0] stage_addr_q;
  pix_pair_t           row_buf_q [COLS];
  pix_pair_t           stage_q   [COLS];
  rgb_t                mem_top_q [ROWS*COLS];
  rgb_t                mem_bot_q [ROWS*COLS];
  logic                rd_valid_q;
  rgb_t                rd_rgb_q;
  logic                err_short_q, err_long_q, err_overrun_q;

  // A latch only starts a commit from IDLE; later ones are dropped as overrun.
  assign lat_accept = lat_rise && (state_q == ST_IDLE);
  // A shift coinciding with a latch belongs to neither row and is dropped.
  assign sclk_wr    = sclk_rise && !lat_rise && (shift_cnt_q < COLS_CNT);

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_done   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lat_rise) begin
          state_d = ST_COMMIT;
          col_d   = '0;
        end
      end
      ST_COMMIT: begin
        col_d = col_q + 1'b1;
        if (col_q == LAST_COL) state_d = ST_DONE;
      end
      ST_DONE: begin
        row_done   = 1'b1;
        frame_done = (stage_addr_q == LAST_ROW);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      shift_cnt_q   <= '0;
      stage_addr_q  <= '0;
      rd_valid_q    <= 1'b0;
      rd_rgb_q      <= '0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;

      if (lat_rise) shift_cnt_q <= '0;
      else if (sclk_wr) shift_cnt_q <= shift_cnt_q + 1'b1;

      if (lat_accept) stage_addr_q <= addr_s;

      // Set wins over a same-cycle clear.
      err_short_q   <= (lat_accept && shift_cnt_q < COLS_CNT) || (err_short_q && !err_clr);
      err_long_q    <= (sclk_rise && !lat_rise && shift_cnt_q == COLS_CNT) || (err_long_q && !err_clr);
      err_overrun_q <= (lat_rise && state_q != ST_IDLE) || (err_overrun_q && !err_clr);

      rd_valid_q <= rd_en;
      if (rd_en) begin
        if (rd_row[ROW_BITS]) rd_rgb_q <= mem_bot_q[{rd_row[ROW_BITS-1:0], rd_col}];
        else                  rd_rgb_q <= mem_top_q[{rd_row[ROW_BITS-1:0], rd_col}];
      end
    end
  end

  // Row buffer, staging copy and frame memory carry no reset.
  always_ff @(posedge clk) begin
    if (sclk_wr) row_buf_q[shift_cnt_q[COL_BITS-1:0]] <= '{rgb0: rgb0_s, rgb1: rgb1_s};
    if (lat_accept) stage_q <= row_buf_q;
    if (state_q == ST_COMMIT) begin
      mem_top_q[{stage_addr_q, col_q}] <= stage_q[col_q].rgb0;
      mem_bot_q[{stage_addr_q, col_q}] <= stage_q[col_q].rgb1;
    end
  end

`ifdef HUB75_RX_OE_CHECK_EN
  logic err_oe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_oe_q <= 1'b0;
    else     err_oe_q <= (lat_rise && !oe_s) || (err_oe_q && !err_clr);
  end

  assign err_oe = err_oe_q;
`else
  logic oe_unused;

  assign oe_unused = oe_s;
  assign err_oe    = 1'b0;
`endif

  assign rd_valid    = rd_valid_q;
  assign rd_rgb      = rd_rgb_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: doc/hub75_rx_capture.md
# hub75_rx_capture

Panel-side receiver for the HUB75 LED-matrix link driven by the matrix output block. It samples the shift clock, row address, six colour lines, OE and LAT, and rebuilds each latched row pair in an internal 32x64 RGB frame memory. The block serves as the on-chip loopback monitor and verification checker for the display path. A random-access read port and sticky protocol-error flags expose the captured frame.

## Interface
- COLS, 64, pixels shifted per row pair.
- ROW_BITS, 4, width of the row-pair address; rows per half = 2^ROW_BITS.
- clk  in  1  system clock; must run at least 4x hub_sclk.
- rst  in  1  reset, asynchronous, active-high.
- hub_sclk  in  1  panel shift clock; data is captured on its rising edge.
- hub_lat  in  1  latch; its rising edge commits the row.
- hub_oe  in  1  output enable, high = blanked.
- hub_addr  in  ROW_BITS  row-pair address {D,C,B,A}.
- hub_rgb0  in  3  {R0,G0,B0}, upper-half pixel.
- hub_rgb1  in  3  {R1,G1,B1}, lower-half pixel.
- rd_en  in  1  read request.
- rd_row  in  ROW_BITS+1  row 0..2^(ROW_BITS+1)-1.
- rd_col  in  6  column 0..COLS-1.
- rd_valid  out  1  read data valid.
- rd_rgb  out  3  {R,G,B} read data.
- row_done  out  1  one-cycle pulse when a commit completes.
- frame_done  out  1  one-cycle pulse alongside row_done when the committed address is 2^ROW_BITS-1.
- err_clr  in  1  clears all sticky error flags.
- err_short, err_long, err_overrun, err_oe  out  1 each  sticky error flags.

## Operation
- Every hub_* input passes through a 2-flop synchronizer. Data, address and OE are delayed with the same depth as sclk and LAT, so they stay aligned.
- A synchronized sclk rise with shift_cnt < COLS writes {rgb0,rgb1} to row_buf[shift_cnt] and then increments shift_cnt. The k-th shift (from 0) lands in column k.
- An sclk rise with shift_cnt == COLS discards the data and sets err_long. shift_cnt saturates at COLS.
- A synchronized LAT rise snapshots hub_addr, row_buf and shift_cnt into staging registers and clears shift_cnt. If the captured count is < COLS, err_short is set.
- Under err_short, unwritten columns keep their previous row_buf contents.
- FSM states:
  - IDLE: goes to COMMIT on a LAT rise.
  - COMMIT: writes one column per cycle, 64 cycles. Staging[c].rgb0 goes to row addr, col c; staging[c].rgb1 goes to row addr+2^ROW_BITS, col c. At c == COLS-1 the FSM goes to DONE.
  - DONE: pulses row_done (and frame_done when applicable), then goes to IDLE.
- Shifting continues into row_buf during COMMIT and DONE.
- A LAT rise while the FSM is not in IDLE sets err_overrun. That latch is dropped, but shift_cnt still clears.
- If a set condition and err_clr occur in the same cycle, the flag is set.
- Frame memory is not reset. Reading an address that has never been written returns undefined data.

## Timing
- Reset values: all outputs 0, FSM in IDLE, shift_cnt 0, synchronizers 0.
- Pin-to-edge-detect latency is 3 clk. Data and sclk must be stable for at least 2 clk on each side of an sclk rise.
- LAT rise detected at cycle t: COMMIT runs t+1..t+COLS, and row_done is high at t+COLS+1.
- Read latency is 1 clk: rd_valid and rd_rgb are valid the cycle after rd_en, and rd_valid is otherwise 0. Reading a cell during its commit cycle returns the old value.
- Reset asserted mid-commit aborts the commit: FSM to IDLE, no row_done, memory partly updated.

## Configuration
- HUB75_RX_OE_CHECK_EN defined: a LAT rise while synchronized hub_oe == 0 sets err_oe, because the panel would display during the load. The commit proceeds normally.
- HUB75_RX_OE_CHECK_EN undefined: err_oe is tied to 0 and the OE input is unused.

## Structure
- hub75_pkg: COLS, ROW_BITS, ROWS, an rgb_t 3-bit typedef, a pix_pair_t {rgb0,rgb1} typedef, and the FSM state encoding.
- Sub-module hub75_rx_sync: parameterized 2-flop synchronizer with rising-edge detect, used for sclk and LAT and as a plain delay for the data, address and OE inputs.

## Test plan
- Full row: addr=5, 64 shifts with rgb0=k%8 and rgb1=7-(k%8), then LAT -> row_done 65 clk after the LAT detect. Read (5,10) -> 3'b010 and (21,10) -> 3'b101, each with rd_valid one clk after rd_en.
- Short row: 40 shifts with rgb0=3'b111 after a full all-zero row, then LAT -> err_short=1. Row cols 0-39 = 7 and cols 40-63 = 0.
- Long row: 70 shifts -> err_long=1, cols 0-63 hold the first 64 pixels, and err_clr returns the flag to 0.
- Overrun: a second LAT 10 clk after the first -> err_overrun=1, exactly one row_done, and the memory holds only the first row's data.
- Frame: addresses 0..15 sent in order -> 16 row_done pulses and exactly one frame_done, coincident with the row-15 row_done. Reset asserted during a later commit -> no row_done.
- OE check: LAT with OE=0 -> err_oe=1 when the macro is defined and 0 when it is undefined. In both cases the row is committed.
